uart_rx: RTL

- UART receiver: the counterpart of the team's UART transmitter. Frame format 8N1, LSB first.
- Synchronizes the asynchronous `rx` line and validates the start bit at mid-bit.
- Samples each data bit at mid-bit, checks the stop bit, then presents the byte with a one-cycle valid pulse.
- Sits between the FPGA RX pin and user logic; the same CLOCK_RATE/BAUD_RATE parameters as the transmitter give a matched link.

---
 rtl/uart_rx.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: two-flop input synchronizer, mid-bit sampling,
// stop-bit check and one-cycle ready / framing-error pulses.
module uart_rx #(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] UART_RX_Data_Out,
    output logic       UART_RX_Ready_Out,
    output logic       UART_RX_Frame_Err,
    output logic       idle
);

    localparam int BIT_PERIOD = CLOCK_RATE / BAUD_RATE;
    localparam int HALF       = BIT_PERIOD / 2;
    localparam int CNT_W      = $clog2(BIT_PERIOD) + 1;

    localparam logic [CNT_W-1:0] BIT_PERIOD_C = CNT_W'(BIT_PERIOD);
    localparam logic [CNT_W-1:0] HALF_C       = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_ONE_C    = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        shift_r;
    logic              s1_r;
    logic              rx_s_r;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r   <= 1'b1;
            rx_s_r <= 1'b1;
        end else begin
            s1_r   <= rx;
            rx_s_r <= s1_r;
        end
    end

    // Receive FSM with registered outputs; idle is updated on every move into or out of IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r           <= IDLE;
            baud_cnt_r        <= {CNT_W{1'b0}};
            bit_cnt_r         <= 3'd0;
            shift_r           <= 8'h00;
            UART_RX_Data_Out  <= 8'h00;
            UART_RX_Ready_Out <= 1'b0;
            UART_RX_Frame_Err <= 1'b0;
            idle              <= 1'b1;
        end else begin
            UART_RX_Ready_Out <= 1'b0;
            UART_RX_Frame_Err <= 1'b0;
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= {CNT_W{1'b0}};
                    if (!rx_s_r) begin
                        state_r <= START;
                        idle    <= 1'b0;
                    end else begin
                        idle    <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt_r == HALF_C) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r  <= 3'd0;
                        if (!rx_s_r) begin
                            state_r <= DATA;
                        end else begin
                            // Start bit did not hold until mid-bit: treat as a glitch.
                            state_r <= IDLE;
                            idle    <= 1'b1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE_C;
                    end
                end
                DATA: begin
                    if (baud_cnt_r == BIT_PERIOD_C) begin
                        shift_r    <= {rx_s_r, shift_r[7:1]};
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        baud_cnt_r <= {CNT_W{1'b0}};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE_C;
                    end
                end
                STOP: begin
                    if (baud_cnt_r == BIT_PERIOD_C) begin
                        baud_cnt_r <= {CNT_W{1'b0}};
                        if (rx_s_r) begin
                            UART_RX_Data_Out  <= shift_r;
                            UART_RX_Ready_Out <= 1'b1;
                            state_r           <= IDLE;
                            idle              <= 1'b1;
                        end else begin
                            UART_RX_Frame_Err <= 1'b1;
                            state_r           <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE_C;
                    end
                end
                WAIT_HIGH: begin
                    // Hold off through a break so a low line is not taken as a new start bit.
                    baud_cnt_r <= {CNT_W{1'b0}};
                    if (rx_s_r) begin
                        state_r <= IDLE;
                        idle    <= 1'b1;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= {CNT_W{1'b0}};
                    idle       <= 1'b1;
                end
            endcase
        end
    end

endmodule
